// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_LOAD  = 2'd1,
    SPI_SHIFT = 2'd2
  } spi_periph_state_t;

  localparam logic [7:0] SPI_DEFAULT_FILL = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall detection on the synchronized value.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchronizer chain, previous-value flop and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], in};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversampled pins, 1-deep tx holding register, back-to-back words.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter int unsigned            SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0]  FILL_BYTE   = DATA_WIDTH'(SPI_DEFAULT_FILL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  frame_active
);

  localparam int unsigned         CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .in(sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .in(cs_n), .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .in(mosi), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = ^{sclk_s, mosi_rise, mosi_fall};

  spi_periph_state_t     state_q, state_n;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_n;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_n;
  logic [DATA_WIDTH-1:0] hold_q, hold_n;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_n;
  logic                  reload_q, reload_n;
  logic                  miso_n, miso_oe_n, rx_valid_n, tx_ready_n, tx_underrun_n, frame_active_n;
  logic [DATA_WIDTH-1:0] rx_data_n;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  do_load;

  // Word for the next load: holding register if full, otherwise the fill pattern.
  assign load_word = tx_ready ? FILL_BYTE : hold_q;
  assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SPI_IDLE;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      hold_q       <= '0;
      bit_cnt_q    <= '0;
      reload_q     <= 1'b0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_ready     <= 1'b1;
      tx_underrun  <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      state_q      <= state_n;
      tx_shift_q   <= tx_shift_n;
      rx_shift_q   <= rx_shift_n;
      hold_q       <= hold_n;
      bit_cnt_q    <= bit_cnt_n;
      reload_q     <= reload_n;
      miso         <= miso_n;
      miso_oe      <= miso_oe_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      tx_ready     <= tx_ready_n;
      tx_underrun  <= tx_underrun_n;
      frame_active <= frame_active_n;
    end
  end

  // Next-state, shift, load and holding-register logic.
  always_comb begin
    state_n        = state_q;
    tx_shift_n     = tx_shift_q;
    rx_shift_n     = rx_shift_q;
    hold_n         = hold_q;
    bit_cnt_n      = bit_cnt_q;
    reload_n       = reload_q;
    miso_n         = miso;
    miso_oe_n      = miso_oe;
    rx_data_n      = rx_data;
    rx_valid_n     = 1'b0;
    tx_ready_n     = tx_ready;
    tx_underrun_n  = 1'b0;
    frame_active_n = frame_active;
    do_load        = 1'b0;

    case (state_q)
      SPI_IDLE: begin
        if (cs_fall) state_n = SPI_LOAD;
      end
      SPI_LOAD: begin
        if (cs_s) begin
          // Select already released again: abandon the frame without consuming data.
          state_n = SPI_IDLE;
        end else begin
          do_load        = 1'b1;
          bit_cnt_n      = '0;
          reload_n       = 1'b0;
          miso_oe_n      = 1'b1;
          frame_active_n = 1'b1;
          state_n        = SPI_SHIFT;
        end
      end
      SPI_SHIFT: begin
        if (sclk_rise) begin
          rx_shift_n = rx_word;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_n  = rx_word;
            rx_valid_n = 1'b1;
            bit_cnt_n  = '0;
            reload_n   = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt_q + CNT_W'(1);
          end
        end
        // Deselect wins over any SCLK fall; a word completing this cycle is kept.
        if (cs_rise) begin
          state_n        = SPI_IDLE;
          bit_cnt_n      = '0;
          reload_n       = 1'b0;
          miso_n         = 1'b0;
          miso_oe_n      = 1'b0;
          frame_active_n = 1'b0;
        end else if (sclk_fall) begin
          if (reload_q) begin
            do_load  = 1'b1;
            reload_n = 1'b0;
          end else begin
            tx_shift_n = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_n     = tx_shift_q[DATA_WIDTH-2];
          end
        end
      end
      default: state_n = SPI_IDLE;
    endcase

    // Load sees the pre-write holding register; a same-cycle write is kept for the next word.
    if (do_load) begin
      tx_shift_n    = load_word;
      miso_n        = load_word[DATA_WIDTH-1];
      tx_underrun_n = tx_ready;
      tx_ready_n    = 1'b1;
    end
    if (tx_valid && tx_ready) begin
      hold_n     = tx_data;
      tx_ready_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: single-word vector table plus multi-word and abort sequences.
`timescale 1ns/1ps
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic       frame_active;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rxq[$];
  int         urun_cnt = 0;

  spi_peripheral #(.DATA_WIDTH(8), .SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  // Collect received words and underrun pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) rxq.push_back(rx_data);
      if (tx_underrun) urun_cnt++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_tx(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_ready_wait: got 0 expected 1 within 400 cycles");
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode-0 frame at clk/16; final SCLK fall coincides with cs_n rise.
  task automatic spi_frame(input int nbits, input logic [31:0] mo,
                           output logic [31:0] mi, output logic act_ok);
    mi     = '0;
    act_ok = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    sclk = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[31-i];
      repeat (8) @(negedge clk);
      mi[31-i] = miso;
      if (!(miso_oe && frame_active)) act_ok = 1'b0;
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      if (i != nbits - 1) sclk = 1'b0;
    end
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic clear_obs();
    rxq.delete();
    urun_cnt = 0;
  endtask

  typedef struct {
    logic       queue_tx;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    int         exp_urun;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] mi;
  logic        act_ok;

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1'b0, 8'h00, 8'hC3, 8'hFF, 1};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 0};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1};

    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_tx_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_frame_active", 32'(frame_active), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single-word frames from the table.
    for (int v = 0; v < 5; v++) begin
      clear_obs();
      if (vecs[v].queue_tx) send_tx(vecs[v].tx);
      spi_frame(8, {vecs[v].mo, 24'h0}, mi, act_ok);
      chk($sformatf("v%0d_miso", v), 32'(mi[31:24]), 32'(vecs[v].exp_miso));
      chk($sformatf("v%0d_rx_count", v), 32'(rxq.size()), 32'd1);
      if (rxq.size() > 0) chk($sformatf("v%0d_rx_data", v), 32'(rxq[0]), 32'(vecs[v].mo));
      chk($sformatf("v%0d_underruns", v), 32'(urun_cnt), 32'(vecs[v].exp_urun));
      chk($sformatf("v%0d_active_during", v), 32'(act_ok), 32'd1);
      chk($sformatf("v%0d_tx_ready", v), 32'(tx_ready), 32'd1);
      chk($sformatf("v%0d_oe_after", v), 32'(miso_oe), 32'd0);
      chk($sformatf("v%0d_fa_after", v), 32'(frame_active), 32'd0);
    end

    // Three back-to-back words, tx fed as the holding register drains.
    clear_obs();
    send_tx(8'h01);
    fork
      spi_frame(24, 32'hDEADBE00, mi, act_ok);
      begin
        send_tx(8'h02);
        send_tx(8'h03);
      end
    join
    chk("b2b_miso", mi[31:8], 32'h00010203);
    chk("b2b_rx_count", 32'(rxq.size()), 32'd3);
    if (rxq.size() == 3) begin
      chk("b2b_rx0", 32'(rxq[0]), 32'hDE);
      chk("b2b_rx1", 32'(rxq[1]), 32'hAD);
      chk("b2b_rx2", 32'(rxq[2]), 32'hBE);
    end
    chk("b2b_underruns", 32'(urun_cnt), 32'd0);
    chk("b2b_active_during", 32'(act_ok), 32'd1);

    // Abort after 5 SCLK edges with a word waiting in the holding register.
    clear_obs();
    send_tx(8'h11);
    fork
      spi_frame(5, 32'hF8000000, mi, act_ok);
      send_tx(8'h22);
    join
    chk("abort_rx_count", 32'(rxq.size()), 32'd0);
    chk("abort_miso_bits", 32'(mi[31:27]), 32'(5'b00010));
    chk("abort_oe", 32'(miso_oe), 32'd0);
    chk("abort_miso", 32'(miso), 32'd0);
    chk("abort_fa", 32'(frame_active), 32'd0);
    chk("abort_hold_kept", 32'(tx_ready), 32'd0);
    clear_obs();
    spi_frame(8, 32'h5A000000, mi, act_ok);
    chk("post_abort_miso", 32'(mi[31:24]), 32'h22);
    chk("post_abort_rx_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) chk("post_abort_rx", 32'(rxq[0]), 32'h5A);
    chk("post_abort_underruns", 32'(urun_cnt), 32'd0);

    // Write lands in the same cycle as the word-2 reload with an empty register.
    clear_obs();
    send_tx(8'hA1);
    fork
      spi_frame(24, 32'h11223300, mi, act_ok);
      begin
        repeat (8) @(negedge sclk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    chk("race_miso", mi[31:8], 32'h00A1FF77);
    chk("race_underruns", 32'(urun_cnt), 32'd1);
    chk("race_rx_count", 32'(rxq.size()), 32'd3);
    if (rxq.size() == 3) chk("race_rx2", 32'(rxq[2]), 32'h33);
    chk("race_tx_ready", 32'(tx_ready), 32'd1);

    // Reset asserted mid-word.
    clear_obs();
    send_tx(8'h42);
    @(negedge clk);
    cs_n = 1'b0;
    send_tx(8'h43);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    chk("pre_rst_fa", 32'(frame_active), 32'd1);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    #1;
    chk("mid_rst_miso", 32'(miso), 32'd0);
    chk("mid_rst_oe", 32'(miso_oe), 32'd0);
    chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_underrun", 32'(tx_underrun), 32'd0);
    chk("mid_rst_fa", 32'(frame_active), 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    clear_obs();
    send_tx(8'h42);
    spi_frame(8, 32'h99000000, mi, act_ok);
    chk("post_rst_miso", 32'(mi[31:24]), 32'h42);
    chk("post_rst_rx_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) chk("post_rst_rx", 32'(rxq[0]), 32'h99);
    chk("post_rst_underruns", 32'(urun_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
